// File: rtl/oam_dma_engine.sv
// Sprite DMA master: copies one LEN-byte page of main memory into PPU OAM on a CPU trigger.
// Latency: ALIGN_CYCLES + LEN + READ_LAT busy cycles per transfer, one OAM write per cycle once the pipeline fills.
// Backpressure: none accepted; the CPU is halted via o_stall, and triggers while busy are dropped.
//
// Ports:
//   i_clk, i_reset          clock, asynchronous active-high reset
//   i_trig, i_trig_page,    CPU strobe to the DMA page register; page and current
//   i_oam_start             OAMADDR are captured with it
//   o_rd_active, o_raddr    memory read port ownership and address
//   i_rdata                 memory read data, READ_LAT cycles after o_raddr
//   o_stall, o_busy         CPU halt / transfer in progress
//   o_oam_wen, o_oam_waddr, o_oam_wdata   OAM write port
//   o_done                  one-cycle completion pulse (first idle cycle)
module oam_dma_engine #(
    parameter int unsigned LEN          = 256,
    parameter int unsigned READ_LAT     = 1,
    parameter int unsigned ALIGN_CYCLES = 1
) (
    input  logic        i_clk,
    input  logic        i_reset,
    input  logic        i_trig,
    input  logic [7:0]  i_trig_page,
    input  logic [7:0]  i_oam_start,
    output logic        o_rd_active,
    output logic [15:0] o_raddr,
    input  logic [7:0]  i_rdata,
    output logic        o_stall,
    output logic        o_oam_wen,
    output logic [7:0]  o_oam_waddr,
    output logic [7:0]  o_oam_wdata,
    output logic        o_busy,
    output logic        o_done
);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_ALIGN = 2'd1,
        S_READ  = 2'd2,
        S_DRAIN = 2'd3
    } state_t;

    // Terminal counts for each timed phase. ALIGN_CYCLES=0 never reaches S_ALIGN,
    // so its terminal value is irrelevant in that build.
    localparam bit       HAS_ALIGN   = (ALIGN_CYCLES != 0);
    localparam logic [7:0] ALIGN_LAST = HAS_ALIGN ? 8'(ALIGN_CYCLES - 1) : 8'd0;
    localparam logic [7:0] READ_LAST  = 8'(LEN - 1);
    localparam logic [7:0] DRAIN_LAST = 8'(READ_LAT - 1);

    state_t      r_state;
    state_t      w_next;
    // Shared phase counter; during S_READ it is the 8-bit source index, so it
    // can never carry into the page byte.
    logic [7:0]  r_cnt;
    logic [7:0]  r_page;
    logic [7:0]  r_start;
    logic        r_done;

    // Write pipeline: stage i holds the read issued i+1 cycles ago. The last
    // stage lines up with the memory returning that read's data.
    logic [READ_LAT-1:0] r_pipe_vld;
    logic [7:0]          r_pipe_addr [READ_LAT];

    logic w_accept;
    logic w_phase_last;

    assign w_accept = (r_state == S_IDLE) && i_trig;

    always_comb begin
        w_phase_last = 1'b0;
        case (r_state)
            S_ALIGN: w_phase_last = (r_cnt == ALIGN_LAST);
            S_READ:  w_phase_last = (r_cnt == READ_LAST);
            S_DRAIN: w_phase_last = (r_cnt == DRAIN_LAST);
            default: w_phase_last = 1'b0;
        endcase
    end

    // ---------------- FSM: state register ----------------
    always_ff @(posedge i_clk or posedge i_reset) begin
        if (i_reset) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    // ---------------- FSM: next-state logic ----------------
    always_comb begin
        w_next = r_state;
        case (r_state)
            S_IDLE: begin
                if (i_trig) begin
                    w_next = HAS_ALIGN ? S_ALIGN : S_READ;
                end
            end
            S_ALIGN: if (w_phase_last) w_next = S_READ;
            S_READ:  if (w_phase_last) w_next = S_DRAIN;
            S_DRAIN: if (w_phase_last) w_next = S_IDLE;
            default: w_next = S_IDLE;
        endcase
    end

    // ---------------- FSM: outputs ----------------
    always_comb begin
        o_rd_active = (r_state == S_READ);
        o_raddr     = o_rd_active ? {r_page, r_cnt} : 16'h0000;
        o_stall     = (r_state != S_IDLE);
        o_busy      = (r_state != S_IDLE);
        o_oam_wen   = r_pipe_vld[READ_LAT-1];
        // Data and address are forced to zero outside write slots so the OAM
        // bus is quiet whenever no byte is being delivered.
        o_oam_waddr = o_oam_wen ? r_pipe_addr[READ_LAT-1] : 8'h00;
        o_oam_wdata = o_oam_wen ? i_rdata : 8'h00;
        o_done      = r_done;
    end

    // ---------------- Datapath ----------------
    always_ff @(posedge i_clk or posedge i_reset) begin
        if (i_reset) begin
            r_cnt   <= 8'h00;
            r_page  <= 8'h00;
            r_start <= 8'h00;
            r_done  <= 1'b0;
        end else begin
            // Counter restarts on every phase change, otherwise counts while busy.
            if (w_next != r_state) begin
                r_cnt <= 8'h00;
            end else if (r_state != S_IDLE) begin
                r_cnt <= r_cnt + 8'h01;
            end

            // Page and start are only captured on an accepted trigger, so a
            // trigger arriving mid-transfer leaves them untouched.
            if (w_accept) begin
                r_page  <= i_trig_page;
                r_start <= i_oam_start;
            end

            // Registered so the pulse lands in the first idle cycle, when
            // stall/busy are already low.
            r_done <= (r_state == S_DRAIN) && w_phase_last;
        end
    end

    always_ff @(posedge i_clk or posedge i_reset) begin
        if (i_reset) begin
            r_pipe_vld <= '0;
            for (int i = 0; i < int'(READ_LAT); i++) begin
                r_pipe_addr[i] <= 8'h00;
            end
        end else begin
            r_pipe_vld[0]  <= (r_state == S_READ);
            // OAM address wraps modulo 256 naturally in 8 bits.
            r_pipe_addr[0] <= r_start + r_cnt;
            for (int i = 1; i < int'(READ_LAT); i++) begin
                r_pipe_vld[i]  <= r_pipe_vld[i-1];
                r_pipe_addr[i] <= r_pipe_addr[i-1];
            end
        end
    end

endmodule
